// File: rtl/c64_bus_pkg.sv
// ============================================================================
// c64_bus_pkg : shared types and constants for the C64 memory-port arbiter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package c64_bus_pkg;

  typedef enum logic [1:0] {
    CPU_OWN = 2'd0,
    BA_WAIT = 2'd1,
    VIC_OWN = 2'd2
  } arb_state_t;

  localparam int unsigned BA_DELAY_DEFAULT = 3;

  // Slot encoding of the phase flop: phi1 belongs to the VIC, phi2 to the CPU.
  localparam logic PH_VIC = 1'b0;
  localparam logic PH_CPU = 1'b1;

endpackage

`default_nettype wire

// File: rtl/c64_bus_arbiter.sv
// ============================================================================
// c64_bus_arbiter : phi1/phi2 sharing of the 64 KiB RAM port, BA/AEC steal
// Revision        : 1.0
// ============================================================================
`default_nettype none

module c64_bus_arbiter
  import c64_bus_pkg::*;
#(
  parameter int unsigned BA_DELAY = BA_DELAY_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_ab,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_we,
  output logic        cpu_ce,
  output logic [7:0]  cpu_di,
  input  logic [13:0] vic_ab,
  input  logic [1:0]  vic_bank,
  input  logic        vic_dma_req,
  output logic [7:0]  vic_di,
  output logic        ba,
  output logic        aec,
  output logic [15:0] mem_ab,
  output logic [7:0]  mem_do,
  output logic        mem_we,
  input  logic [7:0]  mem_di
);

  localparam logic [1:0] CNT_LAST = 2'(BA_DELAY - 1);

  logic       r_ph;
  arb_state_t r_state;
  arb_state_t w_state_next;
  logic [1:0] r_cnt;
  logic [1:0] w_cnt_next;
  logic       r_ba;
  logic       r_aec;
  logic       r_rd_pend;
  logic [7:0] r_cpu_di;
  logic [7:0] r_vic_di;
  logic       w_cpu_slot;
  logic       w_cpu_ce;
  logic       w_mem_we;
  logic [15:0] w_mem_ab;

  assign w_cpu_slot = (r_ph == PH_CPU);

  // State, counter and BA/AEC only move on the edge that closes the CPU slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ph    <= PH_VIC;
      r_state <= CPU_OWN;
      r_cnt   <= 2'd0;
      r_ba    <= 1'b1;
      r_aec   <= 1'b1;
    end else begin
      r_ph <= ~r_ph;
      if (w_cpu_slot) begin
        r_state <= w_state_next;
        r_cnt   <= w_cnt_next;
        r_ba    <= (w_state_next == CPU_OWN);
        r_aec   <= (w_state_next != VIC_OWN);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      CPU_OWN: begin
        if (vic_dma_req) begin
          w_state_next = BA_WAIT;
          w_cnt_next   = 2'd0;
        end
      end
      BA_WAIT: begin
        if (!vic_dma_req) begin
          w_state_next = CPU_OWN;
        end else begin
          w_cnt_next = r_cnt + 2'd1;
          if (r_cnt == CNT_LAST) begin
            w_state_next = VIC_OWN;
          end
        end
      end
      VIC_OWN: begin
        if (!vic_dma_req) begin
          w_state_next = CPU_OWN;
        end
      end
      default: begin
        w_state_next = CPU_OWN;
        w_cnt_next   = 2'd0;
      end
    endcase
  end

  // During BA_WAIT a write is still allowed through; a read is held off.
  always_comb begin
    w_cpu_ce = 1'b0;
    w_mem_we = 1'b0;
    w_mem_ab = {vic_bank, vic_ab};
    if (w_cpu_slot) begin
      case (r_state)
        CPU_OWN: begin
          w_cpu_ce = 1'b1;
          w_mem_we = cpu_we;
          w_mem_ab = cpu_ab;
        end
        BA_WAIT: begin
          w_mem_ab = cpu_ab;
          if (cpu_we) begin
            w_cpu_ce = 1'b1;
            w_mem_we = 1'b1;
          end
        end
        default: begin
          w_cpu_ce = 1'b0;
        end
      endcase
    end
  end

  // RAM data lags its address by one clk, so each capture closes the other slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_pend <= 1'b0;
      r_cpu_di  <= 8'h00;
      r_vic_di  <= 8'h00;
    end else if (w_cpu_slot) begin
      r_vic_di  <= mem_di;
      r_rd_pend <= w_cpu_ce & ~cpu_we;
    end else begin
      if (r_rd_pend) begin
        r_cpu_di <= mem_di;
      end
      r_rd_pend <= 1'b0;
    end
  end

  assign cpu_ce = w_cpu_ce;
  assign cpu_di = r_cpu_di;
  assign vic_di = r_vic_di;
  assign ba     = r_ba;
  assign aec    = r_aec;
  assign mem_ab = w_mem_ab;
  assign mem_do = cpu_do;
  assign mem_we = w_mem_we;

endmodule

`default_nettype wire

// File: tb/tb_c64_bus_arbiter.sv
// ============================================================================
// tb_c64_bus_arbiter : directed + randomized bench against a cycle-level model
// Revision           : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_c64_bus_arbiter;

  localparam int BA_DELAY = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_ab = 16'h0000;
  logic [7:0]  cpu_do = 8'h00;
  logic        cpu_we = 1'b0;
  logic        cpu_ce;
  logic [7:0]  cpu_di;
  logic [13:0] vic_ab = 14'h0000;
  logic [1:0]  vic_bank = 2'b00;
  logic        vic_dma_req = 1'b0;
  logic [7:0]  vic_di;
  logic        ba;
  logic        aec;
  logic [15:0] mem_ab;
  logic [7:0]  mem_do;
  logic        mem_we;
  logic [7:0]  mem_di = 8'h00;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] ram     [0:65535];
  logic [7:0] ref_mem [0:65535];

  // Reference model: run = consecutive system-cycle boundaries with the request high.
  int          run = 0;
  logic [7:0]  exp_cpu_di = 8'h00;
  logic [7:0]  exp_vic_di = 8'h00;
  logic        rd_pending = 1'b0;
  logic [7:0]  rd_val = 8'h00;
  logic        last_granted = 1'b1;

  logic        rnd_req = 1'b0;
  logic        rnd_we = 1'b0;
  logic [15:0] rnd_ab = 16'h0400;
  logic [7:0]  rnd_do = 8'h00;

  always #5 clk = ~clk;

  c64_bus_arbiter #(.BA_DELAY(BA_DELAY)) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_ab      (cpu_ab),
    .cpu_do      (cpu_do),
    .cpu_we      (cpu_we),
    .cpu_ce      (cpu_ce),
    .cpu_di      (cpu_di),
    .vic_ab      (vic_ab),
    .vic_bank    (vic_bank),
    .vic_dma_req (vic_dma_req),
    .vic_di      (vic_di),
    .ba          (ba),
    .aec         (aec),
    .mem_ab      (mem_ab),
    .mem_do      (mem_do),
    .mem_we      (mem_we),
    .mem_di      (mem_di)
  );

  // Synchronous RAM: read data appears one clk after its address.
  always @(posedge clk) begin
    mem_di <= ram[mem_ab];
    if (mem_we) ram[mem_ab] = mem_do;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    run        = 0;
    exp_cpu_di = 8'h00;
    exp_vic_di = 8'h00;
    rd_pending = 1'b0;
    last_granted = 1'b1;
  endtask

  // One system cycle; entered 1ns after the edge that opens the VIC slot.
  task automatic sys_cycle(input logic req, input logic we, input logic [15:0] ab,
                           input logic [7:0] d, input logic [1:0] bank, input logic [13:0] vab);
    logic [15:0] vaddr;
    logic        exp_ba;
    logic        exp_aec;
    logic        exp_ce;
    logic [7:0]  vic_snap;
    vic_dma_req = req;
    cpu_we      = we;
    cpu_ab      = ab;
    cpu_do      = d;
    vic_bank    = bank;
    vic_ab      = vab;
    vaddr   = {bank, vab};
    exp_ba  = (run == 0);
    exp_aec = (run <= BA_DELAY);
    exp_ce  = (run == 0) || ((run <= BA_DELAY) && we);

    @(negedge clk);
    chk16("ph0_mem_ab", mem_ab, vaddr);
    chk1 ("ph0_mem_we", mem_we, 1'b0);
    chk1 ("ph0_cpu_ce", cpu_ce, 1'b0);
    chk1 ("ph0_ba", ba, exp_ba);
    chk1 ("ph0_aec", aec, exp_aec);
    chk8 ("ph0_cpu_di", cpu_di, exp_cpu_di);
    chk8 ("ph0_vic_di", vic_di, exp_vic_di);
    vic_snap = ref_mem[vaddr];
    if (rd_pending) begin
      exp_cpu_di = rd_val;
      rd_pending = 1'b0;
    end

    @(posedge clk);
    @(negedge clk);
    chk1("ph1_cpu_ce", cpu_ce, exp_ce);
    chk1("ph1_mem_we", mem_we, exp_ce && we);
    if (exp_ce || run > BA_DELAY) chk16("ph1_mem_ab", mem_ab, exp_ce ? ab : vaddr);
    if (exp_ce && we) chk8("ph1_mem_do", mem_do, d);
    chk1("ph1_ba", ba, exp_ba);
    chk1("ph1_aec", aec, exp_aec);
    chk8("ph1_cpu_di", cpu_di, exp_cpu_di);
    chk8("ph1_vic_di", vic_di, exp_vic_di);

    if (exp_ce && we) ref_mem[ab] = d;
    if (exp_ce && !we) begin
      rd_pending = 1'b1;
      rd_val     = ref_mem[ab];
    end
    exp_vic_di   = vic_snap;
    run          = req ? run + 1 : 0;
    last_granted = exp_ce;

    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i]     = 8'($urandom);
      ref_mem[i] = ram[i];
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1 ("rst_ba", ba, 1'b1);
    chk1 ("rst_aec", aec, 1'b1);
    chk1 ("rst_cpu_ce", cpu_ce, 1'b0);
    chk1 ("rst_mem_we", mem_we, 1'b0);
    chk8 ("rst_cpu_di", cpu_di, 8'h00);
    chk8 ("rst_vic_di", vic_di, 8'h00);
    chk16("rst_mem_ab", mem_ab, {vic_bank, vic_ab});
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    // Idle alternation
    for (int i = 0; i < 4; i++)
      sys_cycle(1'b0, 1'($urandom_range(0, 1)), 16'(16'h1000 + i), 8'($urandom),
                2'b00, 14'(14'h0800 + i));

    // Read of $D020 holding $0E
    ram[16'hD020]     = 8'h0E;
    ref_mem[16'hD020] = 8'h0E;
    sys_cycle(1'b0, 1'b0, 16'hD020, 8'h00, 2'b00, 14'h0123);
    sys_cycle(1'b0, 1'b1, 16'h3000, 8'h5A, 2'b00, 14'h0124);
    chk8("d020_read", cpu_di, 8'h0E);

    // Steal with three writes in BA_WAIT, then a stalled read
    sys_cycle(1'b1, 1'b0, 16'h2000, 8'h00, 2'b00, 14'h0200);
    sys_cycle(1'b1, 1'b1, 16'h0400, 8'h41, 2'b00, 14'h0201);
    sys_cycle(1'b1, 1'b1, 16'h0400, 8'h42, 2'b00, 14'h0202);
    sys_cycle(1'b1, 1'b1, 16'h0400, 8'h43, 2'b00, 14'h0203);
    chk1("aec_after_three", aec, 1'b0);
    repeat (4) sys_cycle(1'b1, 1'b0, 16'h0400, 8'h00, 2'b00, 14'h0204);
    sys_cycle(1'b0, 1'b0, 16'h0400, 8'h00, 2'b00, 14'h0205);
    sys_cycle(1'b0, 1'b0, 16'h0400, 8'h00, 2'b00, 14'h0206);
    sys_cycle(1'b0, 1'b1, 16'h0500, 8'h99, 2'b00, 14'h0207);
    chk8("steal_readback", cpu_di, 8'h43);
    chk8("ram_0400", ram[16'h0400], 8'h43);

    // Long steal, bank 1, VIC address $0400 -> $4400
    repeat (40) sys_cycle(1'b1, 1'b0, 16'h0600, 8'h00, 2'b01, 14'h0400);
    chk16("long_mem_ab", mem_ab, 16'h4400);
    repeat (3) sys_cycle(1'b0, 1'b0, 16'h0600, 8'h00, 2'b01, 14'h0400);

    // Request dropped in BA_WAIT at cnt=1
    sys_cycle(1'b1, 1'b0, 16'h0400, 8'h00, 2'b00, 14'h0300);
    sys_cycle(1'b1, 1'b0, 16'h0401, 8'h00, 2'b00, 14'h0301);
    sys_cycle(1'b0, 1'b0, 16'h0401, 8'h00, 2'b00, 14'h0302);
    chk1("drop_aec_high", aec, 1'b1);
    sys_cycle(1'b0, 1'b0, 16'h0401, 8'h00, 2'b00, 14'h0303);
    sys_cycle(1'b0, 1'b0, 16'h0402, 8'h00, 2'b00, 14'h0304);

    // Request glitch low for one system cycle
    sys_cycle(1'b1, 1'b0, 16'h0410, 8'h00, 2'b00, 14'h0310);
    sys_cycle(1'b0, 1'b0, 16'h0410, 8'h00, 2'b00, 14'h0311);
    sys_cycle(1'b1, 1'b0, 16'h0410, 8'h00, 2'b00, 14'h0312);
    repeat (2) sys_cycle(1'b0, 1'b0, 16'h0410, 8'h00, 2'b00, 14'h0313);

    // Randomized traffic; stalled reads are re-presented unchanged
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) rnd_req = ~rnd_req;
      if (last_granted) begin
        rnd_we = 1'($urandom_range(0, 1));
        rnd_ab = 16'(16'h0400 + $urandom_range(0, 15));
        rnd_do = 8'($urandom);
      end
      sys_cycle(rnd_req, rnd_we, rnd_ab, rnd_do, 2'($urandom_range(0, 1)),
                14'(14'h0400 + $urandom_range(0, 15)));
    end
    repeat (2) sys_cycle(1'b0, 1'b0, 16'h0400, 8'h00, 2'b00, 14'h0400);

    // Reset asserted while the VIC owns the bus
    repeat (6) sys_cycle(1'b1, 1'b0, 16'h1234, 8'h00, 2'b00, 14'h0100);
    @(posedge clk);
    #2;
    chk1("pre_reset_aec", aec, 1'b0);
    reset = 1'b1;
    #1;
    chk1 ("mid_rst_ba", ba, 1'b1);
    chk1 ("mid_rst_aec", aec, 1'b1);
    chk1 ("mid_rst_cpu_ce", cpu_ce, 1'b0);
    chk1 ("mid_rst_mem_we", mem_we, 1'b0);
    chk8 ("mid_rst_cpu_di", cpu_di, 8'h00);
    chk16("mid_rst_mem_ab", mem_ab, 16'h0100);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++)
      sys_cycle(1'b0, 1'b0, 16'(16'h0400 + i), 8'h00, 2'b00, 14'(14'h0500 + i));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
